// File: rtl/crypto_axi_pkg.sv
// Shared AXI read-path types and constants for the crypto DMA subsystem.
package crypto_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam int unsigned AXI_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick; PRIO0 turns it into a fixed S0-first priority.
module rr_arb2 #(
  parameter bit PRIO0 = 1'b0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (PRIO0) begin
      o_winner = ~i_req0;
    end else if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else begin
      o_winner = ~i_req0;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between two requesters; one burst in flight,
// R channel locked to the burst owner until the RLAST handshake.
module axi_rd_arbiter
  import crypto_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          PRIO0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              grant_id,
  output logic              err_len,
  output logic              err_resp,
  input  logic              err_clr
);

  arb_state_e r_state;
  ar_req_t    r_ar;
  logic       r_grant;
  logic       r_last_grant;
  logic [7:0] r_beat_cnt;
  logic       r_err_len;
  logic       r_err_resp;

  logic       w_arb_valid;
  logic       w_winner;
  ar_req_t    w_req;
  logic       w_rhs;
  logic       w_len_bad;

  rr_arb2 #(.PRIO0(PRIO0)) u_rr_arb2 (
    .i_req0   (s0_arvalid),
    .i_req1   (s1_arvalid),
    .i_last   (r_last_grant),
    .o_valid  (w_arb_valid),
    .o_winner (w_winner)
  );

  always_comb begin
    if (w_winner) begin
      w_req = '{addr: AXI_ADDR_W'(s1_araddr), len: s1_arlen,
                size: s1_arsize, burst: s1_arburst};
    end else begin
      w_req = '{addr: AXI_ADDR_W'(s0_araddr), len: s0_arlen,
                size: s0_arsize, burst: s0_arburst};
    end
  end

  assign s0_arready = (r_state == IDLE) && w_arb_valid && !w_winner;
  assign s1_arready = (r_state == IDLE) && w_arb_valid &&  w_winner;

  assign m_axi_arvalid = (r_state == ADDR);
  assign m_axi_araddr  = ADDR_W'(r_ar.addr);
  assign m_axi_arlen   = r_ar.len;
  assign m_axi_arsize  = r_ar.size;
  assign m_axi_arburst = r_ar.burst;

  // R channel is a pure pass-through to the burst owner while in DATA.
  assign s0_rvalid    = (r_state == DATA) && !r_grant && m_axi_rvalid;
  assign s1_rvalid    = (r_state == DATA) &&  r_grant && m_axi_rvalid;
  assign m_axi_rready = (r_state == DATA) && (r_grant ? s1_rready : s0_rready);
  assign s0_rdata     = m_axi_rdata;
  assign s1_rdata     = m_axi_rdata;
  assign s0_rresp     = m_axi_rresp;
  assign s1_rresp     = m_axi_rresp;
  assign s0_rlast     = m_axi_rlast;
  assign s1_rlast     = m_axi_rlast;

  assign w_rhs     = (r_state == DATA) && m_axi_rvalid && m_axi_rready;
  assign w_len_bad = m_axi_rlast != (r_beat_cnt == r_ar.len);

  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant;
  assign err_len  = r_err_len;
  assign err_resp = r_err_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ar         <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_err_len    <= 1'b0;
      r_err_resp   <= 1'b0;
    end else begin
      if (err_clr) begin
        r_err_len  <= 1'b0;
        r_err_resp <= 1'b0;
      end else if (w_rhs) begin
        if (m_axi_rresp != AXI_RESP_OKAY) r_err_resp <= 1'b1;
        if (w_len_bad)                    r_err_len  <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_ar         <= w_req;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            r_beat_cnt <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_rhs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (m_axi_rlast) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked every cycle against a transaction-level model.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]  s0_arlen = '0, s1_arlen = '0;
  logic [2:0]  s0_arsize = 3'd2, s1_arsize = 3'd2;
  logic [1:0]  s0_arburst = 2'b01, s1_arburst = 2'b01;
  logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic        s0_rready = 1'b1, s1_rready = 1'b1;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0, m_rvalid = 1'b0;
  logic        err_clr = 1'b0;

  logic        o_s0_arready[2], o_s1_arready[2], o_s0_rvalid[2], o_s1_rvalid[2];
  logic        o_s0_rlast[2], o_s1_rlast[2], o_arvalid[2], o_rready[2];
  logic        o_busy[2], o_grant[2], o_elen[2], o_eresp[2];
  logic [31:0] o_s0_rdata[2], o_s1_rdata[2], o_araddr[2];
  logic [1:0]  o_s0_rresp[2], o_s1_rresp[2], o_arburst[2];
  logic [7:0]  o_arlen[2];
  logic [2:0]  o_arsize[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO0(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
      .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(o_s0_arready[g]),
      .s0_rdata(o_s0_rdata[g]), .s0_rresp(o_s0_rresp[g]), .s0_rlast(o_s0_rlast[g]),
      .s0_rvalid(o_s0_rvalid[g]), .s0_rready(s0_rready),
      .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
      .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(o_s1_arready[g]),
      .s1_rdata(o_s1_rdata[g]), .s1_rresp(o_s1_rresp[g]), .s1_rlast(o_s1_rlast[g]),
      .s1_rvalid(o_s1_rvalid[g]), .s1_rready(s1_rready),
      .m_axi_araddr(o_araddr[g]), .m_axi_arlen(o_arlen[g]), .m_axi_arsize(o_arsize[g]),
      .m_axi_arburst(o_arburst[g]), .m_axi_arvalid(o_arvalid[g]), .m_axi_arready(m_arready),
      .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
      .m_axi_rvalid(m_rvalid), .m_axi_rready(o_rready[g]),
      .busy(o_busy[g]), .grant_id(o_grant[g]), .err_len(o_elen[g]),
      .err_resp(o_eresp[g]), .err_clr(err_clr)
    );
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Model: phase 0 = no burst, 1 = address offered, 2 = data flowing.
  int          m_ph[2];
  bit          m_own[2], m_last[2], m_elen[2], m_eresp[2];
  logic [31:0] m_addr[2];
  logic [7:0]  m_len[2], m_cnt[2];
  logic [2:0]  m_size[2];
  logic [1:0]  m_burst[2];
  int          glog[2][$];
  logic [31:0] rx0[2][$], rx1[2][$];

  function automatic bit f_win(int i);
    if (i == 1) return !s0_arvalid;
    if (s0_arvalid && s1_arvalid) return !m_last[i];
    return !s0_arvalid;
  endfunction

  function automatic bit f_rready(int i);
    return (m_ph[i] == 2) && (m_own[i] ? s1_rready : s0_rready);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rhs, w, any;
      if (!rst_n) begin
        m_ph[i] = 0; m_own[i] = 0; m_last[i] = 1; m_elen[i] = 0; m_eresp[i] = 0;
        m_addr[i] = '0; m_len[i] = '0; m_cnt[i] = '0; m_size[i] = '0; m_burst[i] = '0;
      end else begin
        rhs = (m_ph[i] == 2) && m_rvalid && f_rready(i);
        w   = f_win(i);
        any = s0_arvalid || s1_arvalid;
        if (err_clr) begin
          m_elen[i] = 0; m_eresp[i] = 0;
        end else if (rhs) begin
          if (m_rresp != 2'b00) m_eresp[i] = 1;
          if (m_rlast != (m_cnt[i] == m_len[i])) m_elen[i] = 1;
        end
        if (m_ph[i] == 0 && any) begin
          m_own[i] = w; m_last[i] = w; m_ph[i] = 1;
          m_addr[i]  = w ? s1_araddr  : s0_araddr;
          m_len[i]   = w ? s1_arlen   : s0_arlen;
          m_size[i]  = w ? s1_arsize  : s0_arsize;
          m_burst[i] = w ? s1_arburst : s0_arburst;
          glog[i].push_back(int'(w));
        end else if (m_ph[i] == 1 && m_arready) begin
          m_ph[i] = 2; m_cnt[i] = '0;
        end else if (m_ph[i] == 2 && rhs) begin
          m_cnt[i] = m_cnt[i] + 8'd1;
          if (m_rlast) m_ph[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit any, w;
        any = s0_arvalid || s1_arvalid;
        w   = f_win(i);
        chk("busy", i, 32'(o_busy[i]), 32'(m_ph[i] != 0));
        chk("grant_id", i, 32'(o_grant[i]), 32'(m_own[i]));
        chk("s0_arready", i, 32'(o_s0_arready[i]), 32'(m_ph[i] == 0 && any && !w));
        chk("s1_arready", i, 32'(o_s1_arready[i]), 32'(m_ph[i] == 0 && any && w));
        chk("arvalid", i, 32'(o_arvalid[i]), 32'(m_ph[i] == 1));
        if (m_ph[i] == 1) begin
          chk("araddr", i, o_araddr[i], m_addr[i]);
          chk("arlen", i, 32'(o_arlen[i]), 32'(m_len[i]));
          chk("arsize", i, 32'(o_arsize[i]), 32'(m_size[i]));
          chk("arburst", i, 32'(o_arburst[i]), 32'(m_burst[i]));
        end
        chk("s0_rvalid", i, 32'(o_s0_rvalid[i]), 32'(m_ph[i] == 2 && !m_own[i] && m_rvalid));
        chk("s1_rvalid", i, 32'(o_s1_rvalid[i]), 32'(m_ph[i] == 2 && m_own[i] && m_rvalid));
        chk("rready", i, 32'(o_rready[i]), 32'(f_rready(i)));
        chk("s0_rdata", i, o_s0_rdata[i], m_rdata);
        chk("s1_rdata", i, o_s1_rdata[i], m_rdata);
        chk("rresp", i, 32'({o_s0_rresp[i], o_s1_rresp[i]}), 32'({m_rresp, m_rresp}));
        chk("rlast", i, 32'({o_s0_rlast[i], o_s1_rlast[i]}), 32'({m_rlast, m_rlast}));
        chk("err_len", i, 32'(o_elen[i]), 32'(m_elen[i]));
        chk("err_resp", i, 32'(o_eresp[i]), 32'(m_eresp[i]));
        if (o_s0_rvalid[i] && s0_rready) rx0[i].push_back(o_s0_rdata[i]);
        if (o_s1_rvalid[i] && s1_rready) rx1[i].push_back(o_s1_rdata[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_phase(input int stall);
    repeat (stall) tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    m_rvalid = 1'b1; m_rdata = d; m_rresp = resp; m_rlast = last;
    tick();
    m_rvalid = 1'b0; m_rresp = 2'b00; m_rlast = 1'b0;
  endtask

  task automatic req0(input logic [31:0] a, input logic [7:0] len);
    s0_araddr = a; s0_arlen = len; s0_arvalid = 1'b1;
    tick();
    s0_arvalid = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // S0 alone, 4-beat burst
    s0_araddr = 32'h0; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    #1;
    chk("t1_arready_pulse", 0, 32'(o_s0_arready[0]), 32'd1);
    tick();
    s0_arvalid = 1'b0;
    chk("t1_arvalid_lat", 0, 32'(o_arvalid[0]), 32'd1);
    chk("t1_araddr", 0, o_araddr[0], 32'h0);
    chk("t1_arlen", 0, 32'(o_arlen[0]), 32'd3);
    ar_phase(0);
    beat(32'h1000_0000, 2'b00, 1'b0);
    beat(32'h8000_0020, 2'b00, 1'b0);
    beat(32'h0, 2'b00, 1'b0);
    beat(32'h0, 2'b00, 1'b1);
    chk("t1_busy_after", 0, 32'(o_busy[0]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("t1_rx_cnt", i, 32'(rx0[i].size()), 32'd4);
      if (rx0[i].size() == 4) begin
        chk("t1_rx0", i, rx0[i][0], 32'h1000_0000);
        chk("t1_rx1", i, rx0[i][1], 32'h8000_0020);
        chk("t1_rx3", i, rx0[i][3], 32'h0);
      end
      chk("t1_rx1q", i, 32'(rx1[i].size()), 32'd0);
      rx0[i].delete();
      glog[i].delete();
    end

    // Simultaneous requests after reset, twice
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    s0_araddr = 32'h100; s0_arlen = 8'd0; s1_araddr = 32'h200; s1_arlen = 8'd0;
    for (int r = 0; r < 2; r++) begin
      s0_arvalid = 1'b1; s1_arvalid = 1'b1;
      tick(); s0_arvalid = 1'b0;
      ar_phase(0); beat(32'h10 + r, 2'b00, 1'b1);
      tick(); s1_arvalid = 1'b0;
      ar_phase(0); beat(32'h20 + r, 2'b00, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      chk("t2_ngrants", i, 32'(glog[i].size()), 32'd4);
      if (glog[i].size() == 4) begin
        chk("t2_g0", i, 32'(glog[i][0]), 32'd0);
        chk("t2_g1", i, 32'(glog[i][1]), 32'd1);
        chk("t2_g2", i, 32'(glog[i][2]), 32'd0);
        chk("t2_g3", i, 32'(glog[i][3]), 32'd1);
      end
      glog[i].delete();
    end

    // Continuous requests: alternation vs fixed priority
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    repeat (3) begin
      tick(); ar_phase(0); beat(32'h30, 2'b00, 1'b1);
    end
    s0_arvalid = 1'b0;
    tick(); s1_arvalid = 1'b0;
    ar_phase(0); beat(32'h31, 2'b00, 1'b1);
    chk("t3_ngrants", 0, 32'(glog[0].size()), 32'd4);
    chk("t3_ngrants", 1, 32'(glog[1].size()), 32'd4);
    if (glog[0].size() == 4 && glog[1].size() == 4) begin
      chk("t3_rr_g1", 0, 32'(glog[0][1]), 32'd1);
      chk("t3_rr_g2", 0, 32'(glog[0][2]), 32'd0);
      chk("t3_fix_g1", 1, 32'(glog[1][1]), 32'd0);
      chk("t3_fix_g2", 1, 32'(glog[1][2]), 32'd0);
      chk("t3_fix_g3", 1, 32'(glog[1][3]), 32'd1);
    end

    // AR stall then R backpressure on an 8-beat S1 burst
    for (int i = 0; i < 2; i++) rx1[i].delete();
    s1_araddr = 32'h2000; s1_arlen = 8'd7; s1_arsize = 3'd2; s1_arburst = 2'b01;
    s1_arvalid = 1'b1; tick(); s1_arvalid = 1'b0;
    ar_phase(5);
    for (int k = 0; k < 8; k++) begin
      s1_rready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hA0 + k; m_rlast = (k == 7);
      tick();
      s1_rready = 1'b1;
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      chk("t4_rx_cnt", i, 32'(rx1[i].size()), 32'd8);
      if (rx1[i].size() == 8) begin
        chk("t4_rx0", i, rx1[i][0], 32'hA0);
        chk("t4_rx4", i, rx1[i][4], 32'hA4);
        chk("t4_rx7", i, rx1[i][7], 32'hA7);
      end
    end

    // Error flags
    req0(32'h300, 8'd3); ar_phase(0);
    beat(32'h11, 2'b00, 1'b0); beat(32'h22, 2'b00, 1'b1);
    chk("t5_elen_early", 0, 32'(o_elen[0]), 32'd1);
    chk("t5_eresp_clean", 0, 32'(o_eresp[0]), 32'd0);
    chk("t5_idle", 0, 32'(o_busy[0]), 32'd0);
    req0(32'h310, 8'd0); ar_phase(0); beat(32'h33, 2'b10, 1'b1);
    chk("t5_eresp", 0, 32'(o_eresp[0]), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_clr_len", 0, 32'(o_elen[0]), 32'd0);
    chk("t5_clr_resp", 0, 32'(o_eresp[0]), 32'd0);
    req0(32'h320, 8'd0); ar_phase(0);
    err_clr = 1'b1; beat(32'h34, 2'b10, 1'b1); err_clr = 1'b0;
    chk("t5_clr_wins", 0, 32'(o_eresp[0]), 32'd0);
    req0(32'h330, 8'd0); ar_phase(0); beat(32'h35, 2'b10, 1'b1);
    chk("t5_eresp_later", 0, 32'(o_eresp[0]), 32'd1);

    // Reset in the middle of a data burst
    req0(32'h400, 8'd3); ar_phase(0);
    beat(32'h55, 2'b00, 1'b0); beat(32'h66, 2'b00, 1'b0);
    m_rvalid = 1'b1; m_rdata = 32'h77;
    rst_n = 1'b0; tick(); rst_n = 1'b1; m_rvalid = 1'b0;
    chk("t6_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("t6_eresp", 0, 32'(o_eresp[0]), 32'd0);
    chk("t6_rready", 0, 32'(o_rready[0]), 32'd0);
    for (int i = 0; i < 2; i++) rx1[i].delete();
    s1_araddr = 32'h500; s1_arlen = 8'd0;
    s1_arvalid = 1'b1; tick(); s1_arvalid = 1'b0;
    chk("t6_grant_s1", 0, 32'(o_grant[0]), 32'd1);
    chk("t6_araddr", 0, o_araddr[0], 32'h500);
    ar_phase(0); beat(32'h88, 2'b00, 1'b1);
    chk("t6_rx_cnt", 0, 32'(rx1[0].size()), 32'd1);
    if (rx1[0].size() == 1) chk("t6_rx", 0, rx1[0][0], 32'h88);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
